// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the narrow-to-wide stream packer.
// Width helpers are functions because the sizes depend on instance parameters.
package stream_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // The timer only ever counts to timeout-1 before expiring.
  function automatic int timer_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/stream_idle_timer.sv
// Idle-cycle counter: pulses o_expire in the cycle that completes TIMEOUT enabled cycles.
// Combinational expire, so the owner can act on the same clock edge.
module stream_idle_timer
  import stream_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int TMR_W = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_cnt;

  assign o_expire = i_en & (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_upsize_pipe.sv
// Packs up to T_DATA_RATIO narrow beats into one wide word (pack register -> output register).
// A closed word skips the pack and lands in the output register when that register is free.
module stream_upsize_pipe
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 4,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic                                 s_last_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  output logic [T_DATA_RATIO*T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_DATA_RATIO-1:0]              m_keep_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam int CNT_W = cnt_width(T_DATA_RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(T_DATA_RATIO - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_pack_data;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_out_data;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] w_word_data;
  logic [T_DATA_RATIO-1:0]                   r_pack_keep;
  logic [T_DATA_RATIO-1:0]                   r_out_keep;
  logic [T_DATA_RATIO-1:0]                   w_word_keep;
  logic [CNT_W-1:0]                          r_cnt;
  logic                                      r_pack_last;
  logic                                      r_out_last;
  logic                                      r_out_vld;

  logic w_acc;
  logic w_out_free;
  logic w_close;
  logic w_word_last;
  logic w_expire;
  logic w_tmr_en;
  logic w_direct_out;
  logic w_pack_to_out;

  assign s_ready_o  = (r_state == FILL) & ~rst;
  assign w_acc      = s_valid_i & s_ready_o;
  assign w_out_free = ~r_out_vld | m_ready_i;

  // Timer can only fire on a non-accept cycle, so an accept always wins over a flush.
  assign w_tmr_en    = (r_state == FILL) & (r_cnt != '0) & ~w_acc;
  assign w_word_last = w_acc & s_last_i;
  assign w_close     = (w_acc & ((r_cnt == LAST_LANE) | s_last_i)) | w_expire;

  assign w_direct_out  = (r_state == FILL) & w_close & w_out_free;
  assign w_pack_to_out = (r_state == HOLD) & w_out_free;

  generate
    if (FLUSH_TIMEOUT > 0) begin : g_timer
      stream_idle_timer #(
        .TIMEOUT(FLUSH_TIMEOUT)
      ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (~w_tmr_en),
        .i_en    (w_tmr_en),
        .o_expire(w_expire)
      );
    end else begin : g_no_timer
      assign w_expire = 1'b0;
    end
  endgenerate

  // Current pack merged with the incoming beat; unfilled lanes stay zero because the pack is cleared on close.
  always_comb begin
    w_word_data = r_pack_data;
    w_word_keep = r_pack_keep;
    if (w_acc) begin
      w_word_data[r_cnt] = s_data_i;
      w_word_keep[r_cnt] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_close && !w_out_free) w_state_nxt = HOLD;
      HOLD:    if (w_out_free) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_direct_out || w_pack_to_out) begin
      r_pack_data <= '0;
      r_pack_keep <= '0;
      r_pack_last <= 1'b0;
      r_cnt       <= '0;
    end else if (w_acc || w_close) begin
      r_pack_data <= w_word_data;
      r_pack_keep <= w_word_keep;
      r_pack_last <= w_word_last;
      if (!w_close) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_keep <= '0;
      r_out_last <= 1'b0;
      r_out_vld  <= 1'b0;
    end else if (w_direct_out) begin
      r_out_data <= w_word_data;
      r_out_keep <= w_word_keep;
      r_out_last <= w_word_last;
      r_out_vld  <= 1'b1;
    end else if (w_pack_to_out) begin
      r_out_data <= r_pack_data;
      r_out_keep <= r_pack_keep;
      r_out_last <= r_pack_last;
      r_out_vld  <= 1'b1;
    end else if (w_out_free) begin
      r_out_vld <= 1'b0;
    end
  end

  assign m_data_o  = r_out_data;
  assign m_keep_o  = r_out_keep;
  assign m_last_o  = r_out_last;
  assign m_valid_o = r_out_vld;

endmodule

// File: tb/tb_stream_upsize_pipe.sv
// Directed and randomised checks for stream_upsize_pipe with hand-computed expected words.
module tb_stream_upsize_pipe;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int TO = 8;
  localparam int DW = R * W;
  localparam int NB = 1000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic [R-1:0]  m_keep_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;

  word_t got_q[$];
  word_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  stream_upsize_pipe #(
    .T_DATA_WIDTH (W),
    .T_DATA_RATIO (R),
    .FLUSH_TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_keep_o (m_keep_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  // Handshake completes at the next rising edge; inputs are stable across the negedge sample.
  always @(negedge clk) begin
    if (!rst && m_valid_o && m_ready_i) got_q.push_back('{m_data_o, m_keep_o, m_last_o});
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic l, output int waited);
    s_data_i  = W'(d);
    s_last_i  = l;
    s_valid_i = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!s_ready_o && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check($sformatf("send_accept_%0d", d), DW'(s_ready_o), DW'(1));
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [DW-1:0] data, input logic [R-1:0] keep,
                             input logic last);
    int    t;
    word_t w;
    t = 0;
    while (got_q.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_present"}, DW'(got_q.size() != 0), DW'(1));
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
      check({tag, "_data"}, w.data, data);
      check({tag, "_keep"}, DW'(w.keep), DW'(keep));
      check({tag, "_last"}, DW'(w.last), DW'(last));
    end
  endtask

  initial begin
    int    wt;
    int    tot;
    int    quiet;
    int    idx;
    int    gap;
    int    budget;
    int    lane;
    logic  acc;
    logic  beat_last[NB];
    word_t cur;
    word_t g;
    word_t e;

    rst       = 1'b1;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", DW'(s_ready_o), DW'(0));
    check("rst_m_valid", DW'(m_valid_o), DW'(0));
    check("rst_m_data", m_data_o, DW'(0));
    check("rst_m_keep", DW'(m_keep_o), DW'(0));
    check("rst_m_last", DW'(m_last_o), DW'(0));
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", DW'(s_ready_o), DW'(1));
    sync();

    // Full words back-to-back.
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(i, i == 7, wt);
      tot += wt;
    end
    check("t1_no_stall", DW'(tot), DW'(0));
    expect_word("t1_w0", pack4(0, 1, 2, 3), 4'b1111, 1'b0);
    expect_word("t1_w1", pack4(4, 5, 6, 7), 4'b1111, 1'b1);
    sync();

    // Short packets.
    send(10, 1'b0, wt);
    send(11, 1'b1, wt);
    expect_word("t2_w0", pack4(10, 11, 0, 0), 4'b0011, 1'b1);
    sync();
    send(5, 1'b1, wt);
    expect_word("t2_w1", pack4(5, 0, 0, 0), 4'b0001, 1'b1);
    sync();

    // Backpressure: one word stalled in the output register, one closed in the pack.
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(50 + i, i == 7, wt);
    @(negedge clk);
    check("t3_ready_low", DW'(s_ready_o), DW'(0));
    check("t3_valid", DW'(m_valid_o), DW'(1));
    check("t3_keep", DW'(m_keep_o), DW'(4'b1111));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_stable%0d", i), m_data_o, pack4(50, 51, 52, 53));
      @(negedge clk);
    end
    check("t3_none_out", DW'(got_q.size()), DW'(0));
    sync();
    m_ready_i = 1'b1;
    expect_word("t3_w0", pack4(50, 51, 52, 53), 4'b1111, 1'b0);
    expect_word("t3_w1", pack4(54, 55, 56, 57), 4'b1111, 1'b1);
    @(negedge clk);
    check("t3_ready_back", DW'(s_ready_o), DW'(1));
    repeat (3) @(negedge clk);
    check("t3_no_dup", DW'(got_q.size()), DW'(0));
    sync();

    // Idle flush after TO idle cycles.
    send(20, 1'b0, wt);
    send(21, 1'b0, wt);
    send(22, 1'b0, wt);
    quiet = 0;
    repeat (TO) begin
      @(negedge clk);
      if (m_valid_o) quiet++;
    end
    check("t4_early_flush", DW'(quiet), DW'(0));
    @(negedge clk);
    check("t4_flush_vld", DW'(m_valid_o), DW'(1));
    expect_word("t4_flush", pack4(20, 21, 22, 0), 4'b0111, 1'b0);
    sync();

    // Accept on the expiry cycle beats the flush.
    send(20, 1'b0, wt);
    send(21, 1'b0, wt);
    send(22, 1'b0, wt);
    repeat (TO - 1) @(posedge clk);
    #1;
    send(23, 1'b0, wt);
    expect_word("t4b_full", pack4(20, 21, 22, 23), 4'b1111, 1'b0);
    repeat (TO + 4) @(negedge clk);
    check("t4b_no_flush", DW'(got_q.size()), DW'(0));
    sync();

    // Reset discards stalled output and partial pack.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(30 + i, 1'b0, wt);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", DW'(m_valid_o), DW'(0));
    check("t5_keep", DW'(m_keep_o), DW'(0));
    m_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_partial", DW'(got_q.size()), DW'(0));
    sync();
    send(40, 1'b1, wt);
    expect_word("t5_after", pack4(40, 0, 0, 0), 4'b0001, 1'b1);
    sync();

    // Random stress; gaps stay far below the flush timeout so no flush occurs.
    cur  = '0;
    lane = 0;
    for (int i = 0; i < NB; i++) begin
      beat_last[i] = ($urandom_range(0, 4) == 0) || (i == NB - 1);
      cur.data[lane*W +: W] = W'(1000 + i);
      cur.keep[lane] = 1'b1;
      lane++;
      if (lane == R || beat_last[i]) begin
        cur.last = beat_last[i];
        exp_q.push_back(cur);
        cur  = '0;
        lane = 0;
      end
    end
    idx    = 0;
    gap    = 0;
    budget = 0;
    while (idx < NB && budget < 20000) begin
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        idx++;
        gap       = $urandom_range(0, 2);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
      end
      if (!s_valid_i && idx < NB) begin
        if (gap == 0) begin
          s_data_i  = W'(1000 + idx);
          s_last_i  = beat_last[idx];
          s_valid_i = 1'b1;
        end else begin
          gap--;
        end
      end
      m_ready_i = ($urandom_range(0, 3) != 0);
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b1;
    check("t6_all_sent", DW'(idx), DW'(NB));
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    check("t6_count", DW'(got_q.size()), DW'(exp_q.size()));
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("t6_data", g.data, e.data);
      check("t6_keep", DW'(g.keep), DW'(e.keep));
      check("t6_last", DW'(g.last), DW'(e.last));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
